avalon_pio_irq: RTL and testbench

- Parametrised Avalon-MM general-purpose I/O slave; successor to the fixed 8-bit output-only PIO.
- Adds:
  - configurable width and reset value
  - per-bit direction
  - synchronised inputs
  - edge capture
  - maskable interrupt
- Sits on the system interconnect as a zero-wait-state slave driving board pins.

---
 rtl/pio_pkg.sv | 17 +
 rtl/pio_sync_edge.sv | 54 +++++
 rtl/avalon_pio_irq.sv | 110 +++++++++++
 tb/tb_avalon_pio_irq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO slave: register addresses,
// edge-capture modes and interrupt source modes.
package pio_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;
endpackage

// File: rtl/pio_sync_edge.sv
// Input path of the PIO: two-flop synchroniser, previous-value flop, warm-up
// counter and the per-bit edge vector (only bits configured as inputs).
module pio_sync_edge import pio_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);
  logic [WIDTH-1:0] meta_r, sync_r, prev_r;
  logic [1:0]       warm_r;
  logic [WIDTH-1:0] rise_s, fall_s, raw_s;

  // Synchroniser chain, previous-value flop and saturating warm-up counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
      prev_r <= {WIDTH{1'b0}};
      warm_r <= 2'd0;
    end else begin
      meta_r <= in_port;
      sync_r <= meta_r;
      prev_r <= sync_r;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  // Edge selection; suppressed until the synchroniser holds real pin values
  always_comb begin
    rise_s = sync_r & ~prev_r;
    fall_s = ~sync_r & prev_r;
    case (EDGE_TYPE)
      EDGE_RISING:  raw_s = rise_s;
      EDGE_FALLING: raw_s = fall_s;
      default:      raw_s = rise_s | fall_s;
    endcase
    if (warm_r == 2'd3) begin
      edge_det = raw_s & ~dir;
    end else begin
      edge_det = {WIDTH{1'b0}};
    end
  end

  assign sync_in = sync_r;
endmodule

// File: rtl/avalon_pio_irq.sv
// Parametrised Avalon-MM PIO slave with direction, edge capture and IRQ.
// Optional OUTSET/OUTCLEAR registers are built when PIO_BITSET_EN is defined.
module avalon_pio_irq import pio_pkg::*; #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               IRQ_MODE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);
  logic [WIDTH-1:0] data_r, dir_r, mask_r, cap_r;
  logic             irq_r;
  logic [WIDTH-1:0] data_nxt_s, sync_s, edge_s, wdata_s, clr_s;
  logic             wr_s, irq_nxt_s, unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign wdata_s  = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;

  pio_sync_edge #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .dir      (dir_r),
    .sync_in  (sync_s),
    .edge_det (edge_s)
  );

  // Next data_out value from DATA and, when built, OUTSET/OUTCLEAR writes
  always_comb begin
    data_nxt_s = data_r;
    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_nxt_s = wdata_s;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET: data_nxt_s = data_r | wdata_s;
        ADDR_OUTCLR: data_nxt_s = data_r & ~wdata_s;
`endif
        default:     data_nxt_s = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Write-1-to-clear mask and interrupt source selection
  always_comb begin
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    if (IRQ_MODE == IRQ_LEVEL) begin
      irq_nxt_s = |(sync_s & ~dir_r & mask_r);
    end else begin
      irq_nxt_s = |(cap_r & mask_r);
    end
  end

  // Control registers; a fresh edge overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= RESET_VALUE;
      dir_r  <= {WIDTH{1'b0}};
      mask_r <= {WIDTH{1'b0}};
      cap_r  <= {WIDTH{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      data_r <= data_nxt_s;
      if (wr_s && (address == ADDR_DIR)) begin
        dir_r <= wdata_s;
      end else begin
        dir_r <= dir_r;
      end
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= wdata_s;
      end else begin
        mask_r <= mask_r;
      end
      cap_r <= (cap_r & ~clr_s) | edge_s;
      irq_r <= irq_nxt_s;
    end
  end

  // Zero-latency read mux; unused and set/clear addresses read zero
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = (dir_r & data_r) | (~dir_r & sync_s);
      ADDR_DIR:  readdata[WIDTH-1:0] = dir_r;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_r;
      ADDR_EDGE: readdata[WIDTH-1:0] = cap_r;
      default:   readdata = 32'd0;
    endcase
  end

  assign out_port = data_r;
  assign out_en   = dir_r;
  assign irq      = irq_r;
endmodule

// File: tb/tb_avalon_pio_irq.sv
// Directed self-checking bench: instance A (edge IRQ, RESET_VALUE A5) and
// instance B (level IRQ) share the clock, reset and bus signals.
module tb_avalon_pio_irq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata, rd_a, rd_b;
  logic [7:0]  in_a, in_b, out_a, en_a, out_b, en_b;
  logic        irq_a, irq_b;
  int          checks = 0;
  int          errors = 0;

`ifdef PIO_BITSET_EN
  localparam logic [7:0] EXP_SET = 8'hFF;
  localparam logic [7:0] EXP_CLR = 8'h7E;
`else
  localparam logic [7:0] EXP_SET = 8'h0F;
  localparam logic [7:0] EXP_CLR = 8'h0F;
`endif

  always #5 clk = ~clk;

  avalon_pio_irq #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .IRQ_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .out_en(en_a), .irq(irq_a)
  );

  avalon_pio_irq #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .out_en(en_b), .irq(irq_b)
  );

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic sel, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    cs_a      = ~sel;
    cs_b      = sel;
    write_n   = 1'b0;
    @(negedge clk);
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic check_read(input logic sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check_value(tag, sel ? rd_b : rd_a, exp);
  endtask

  initial begin
    reset_n = 1'b0; in_a = 8'hFF; in_b = 8'h00;
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;

    // Reset with pins high
    repeat (3) @(negedge clk);
    check_value("rst_out_a", out_a, 8'hA5);
    check_value("rst_en_a", en_a, 8'h00);
    check_value("rst_irq_a", irq_a, 1'b0);
    check_value("rst_out_b", out_b, 8'h00);
    check_value("rst_en_b", en_b, 8'h00);
    check_value("rst_irq_b", irq_b, 1'b0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_read(1'b0, 3'd3, 32'h0, "warm_no_edge");
    check_read(1'b0, 3'd0, 32'hFF, "rst_sync_data");
    check_value("warm_irq_a", irq_a, 1'b0);

    // Mixed direction read
    @(negedge clk);
    in_a = 8'hA0;
    bus_write(1'b0, 3'd1, 32'h0F);
    bus_write(1'b0, 3'd0, 32'h3C);
    check_read(1'b0, 3'd0, 32'hAC, "mixed_read");
    check_value("mixed_out", out_a, 8'h3C);
    check_value("mixed_en", en_a, 8'h0F);

    // Rising edge capture and IRQ latency on bit 7
    bus_write(1'b0, 3'd1, 32'h00);
    bus_write(1'b0, 3'd2, 32'h80);
    in_a = 8'h20;
    repeat (4) @(negedge clk);
    check_read(1'b0, 3'd3, 32'h0, "fall_no_capture");
    check_value("fall_no_irq", irq_a, 1'b0);
    in_a = 8'hA0;
    @(negedge clk);
    check_read(1'b0, 3'd0, 32'h20, "lat_k_data");
    @(negedge clk);
    check_read(1'b0, 3'd0, 32'hA0, "lat_k1_data");
    check_read(1'b0, 3'd3, 32'h0, "lat_k1_edge");
    @(negedge clk);
    check_read(1'b0, 3'd3, 32'h80, "lat_k2_edge");
    check_value("lat_k2_irq", irq_a, 1'b0);
    @(negedge clk);
    check_value("lat_k3_irq", irq_a, 1'b1);
    bus_write(1'b0, 3'd3, 32'h80);
    check_read(1'b0, 3'd3, 32'h0, "clr_edge");
    check_value("clr_irq_hold", irq_a, 1'b1);
    @(negedge clk);
    check_value("clr_irq_drop", irq_a, 1'b0);

    // Same-cycle edge and clear on bit 2
    in_a = 8'hA4;
    @(negedge clk);
    @(negedge clk);
    bus_write(1'b0, 3'd3, 32'h04);
    check_read(1'b0, 3'd3, 32'h04, "collide_set_wins");
    bus_write(1'b0, 3'd3, 32'h04);
    check_read(1'b0, 3'd3, 32'h0, "collide_then_clr");

    // Unused addresses and bit set/clear
    bus_write(1'b0, 3'd1, 32'hFF);
    bus_write(1'b0, 3'd0, 32'h0F);
    check_read(1'b0, 3'd0, 32'h0F, "data_0f");
    bus_write(1'b0, 3'd6, 32'hFF);
    check_read(1'b0, 3'd0, 32'h0F, "addr6_ignored");
    check_read(1'b0, 3'd6, 32'h0, "addr6_read");
    check_read(1'b0, 3'd7, 32'h0, "addr7_read");
    @(negedge clk);
    bus_write(1'b0, 3'd4, 32'hF0);
    check_read(1'b0, 3'd0, {24'h0, EXP_SET}, "outset_data");
    check_value("outset_port", out_a, EXP_SET);
    bus_write(1'b0, 3'd5, 32'h81);
    check_read(1'b0, 3'd0, {24'h0, EXP_CLR}, "outclr_data");
    check_read(1'b0, 3'd4, 32'h0, "addr4_read");
    check_read(1'b0, 3'd5, 32'h0, "addr5_read");

    // Level IRQ on instance B
    @(negedge clk);
    bus_write(1'b1, 3'd2, 32'h01);
    in_b = 8'h01;
    @(negedge clk);
    check_value("lvl_k_irq", irq_b, 1'b0);
    @(negedge clk);
    check_value("lvl_k1_irq", irq_b, 1'b0);
    @(negedge clk);
    check_value("lvl_k2_irq", irq_b, 1'b1);
    repeat (3) @(negedge clk);
    check_value("lvl_hold_irq", irq_b, 1'b1);
    in_b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_value("lvl_rel_k1_irq", irq_b, 1'b1);
    @(negedge clk);
    check_value("lvl_rel_k2_irq", irq_b, 1'b0);

    // Asynchronous reset mid-operation
    in_b = 8'h01;
    repeat (4) @(negedge clk);
    check_value("lvl_again_irq", irq_b, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("async_rst_irq_b", irq_b, 1'b0);
    check_value("async_rst_out_a", out_a, 8'hA5);
    check_value("async_rst_en_a", en_a, 8'h00);
    check_read(1'b1, 3'd2, 32'h0, "async_rst_mask_b");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
